// File: rtl/hex_parser_pkg.sv
// Shared definitions for the ASCII hex token parser: state encoding, ASCII
// constants and character helpers (hexvalue is the inverse of hexdigit).
package hex_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIGITS = 2'd1,
    ST_ERROR  = 2'd2
  } parse_state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_LF    = 8'h0a;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_COMMA = 8'h2c;

  // Returns {valid, nibble}; letters map via low nibble + 9 ('a' = 0x61 -> 10).
  function automatic logic [4:0] hexvalue(input logic [7:0] ch);
    logic [4:0] res;
    if ((ch >= 8'h30) && (ch <= 8'h39)) begin
      res = {1'b1, ch[3:0]};
    end else if (((ch >= 8'h61) && (ch <= 8'h66)) || ((ch >= 8'h41) && (ch <= 8'h46))) begin
      res = {1'b1, ch[3:0] + 4'd9};
    end else begin
      res = 5'd0;
    end
    return res;
  endfunction

  function automatic logic is_eol_char(input logic [7:0] ch);
    return (ch == ASCII_CR) || (ch == ASCII_LF);
  endfunction

  function automatic logic is_delim_char(input logic [7:0] ch);
    return is_eol_char(ch) || (ch == ASCII_SPACE) || (ch == ASCII_TAB) || (ch == ASCII_COMMA);
  endfunction

endpackage

// File: rtl/hex_parser_classify.sv
// Combinational ASCII character classifier for hex-text command parsing.
module hex_parser_classify
  import hex_parser_pkg::*;
(
  input  logic [7:0] in_data,
  output logic       is_digit,
  output logic       is_delim,
  output logic       is_eol,
  output logic [3:0] nibble
);

  logic [4:0] hv_s;

  assign hv_s     = hexvalue(in_data);
  assign is_digit = hv_s[4];
  assign nibble   = hv_s[3:0];
  assign is_delim = is_delim_char(in_data);
  assign is_eol   = is_eol_char(in_data);

endmodule

// File: rtl/hex_parser.sv
// Streaming ASCII hex decoder: accumulates hex digits and emits the value on
// a delimiter, or an error pulse for a malformed / overlong token.
module hex_parser
  import hex_parser_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          in_data,
  input  logic                                in_strobe,
  output logic [WIDTH-1:0]                    value,
  output logic [$clog2((WIDTH/4)+1)-1:0]      digits,
  output logic                                eol,
  output logic                                value_strobe,
  output logic                                error_strobe
);

  localparam int MAX_DIGITS = WIDTH / 4;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  parse_state_t     state_r, state_next_s;
  logic [WIDTH-1:0] acc_r, acc_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             emit_value_s, emit_error_s;
  logic             is_digit_s, is_delim_s, is_eol_s;
  logic [3:0]       nibble_s;

  hex_parser_classify u_classify (
    .in_data  (in_data),
    .is_digit (is_digit_s),
    .is_delim (is_delim_s),
    .is_eol   (is_eol_s),
    .nibble   (nibble_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; transitions only on strobed bytes
  always_comb begin
    state_next_s = state_r;
    if (in_strobe) begin
      case (state_r)
        ST_IDLE: begin
          if (is_digit_s) begin
            state_next_s = ST_DIGITS;
          end else if (is_delim_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_ERROR;
          end
        end
        ST_DIGITS: begin
          if (is_digit_s) begin
            state_next_s = (cnt_r == MAX_CNT) ? ST_ERROR : ST_DIGITS;
          end else if (is_delim_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_ERROR;
          end
        end
        ST_ERROR: begin
          if (is_delim_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_ERROR;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Datapath and strobe decode for the current byte
  always_comb begin
    acc_next_s   = acc_r;
    cnt_next_s   = cnt_r;
    emit_value_s = 1'b0;
    emit_error_s = 1'b0;
    if (in_strobe) begin
      case (state_r)
        ST_IDLE: begin
          if (is_digit_s) begin
            acc_next_s = WIDTH'(nibble_s);
            cnt_next_s = CNT_W'(1);
          end else begin
            acc_next_s = acc_r;
          end
        end
        ST_DIGITS: begin
          if (is_digit_s && (cnt_r != MAX_CNT)) begin
            // Shift form stays legal for WIDTH == 4
            acc_next_s = (acc_r << 4) | WIDTH'(nibble_s);
            cnt_next_s = cnt_r + CNT_W'(1);
          end else if (is_delim_s) begin
            emit_value_s = 1'b1;
          end else begin
            acc_next_s = acc_r;
          end
        end
        ST_ERROR: begin
          if (is_delim_s) begin
            emit_error_s = 1'b1;
          end else begin
            emit_error_s = 1'b0;
          end
        end
        default: begin
          emit_value_s = 1'b0;
        end
      endcase
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Accumulator and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r        <= '0;
      cnt_r        <= '0;
      value        <= '0;
      digits       <= '0;
      eol          <= 1'b0;
      value_strobe <= 1'b0;
      error_strobe <= 1'b0;
    end else begin
      acc_r        <= acc_next_s;
      cnt_r        <= cnt_next_s;
      value_strobe <= emit_value_s;
      error_strobe <= emit_error_s;
      if (emit_value_s) begin
        value  <= acc_r;
        digits <= cnt_r;
        eol    <= is_eol_s;
      end
    end
  end

endmodule

// File: tb/tb_hex_parser.sv
// Directed self-checking bench for hex_parser with WIDTH = 32.
module tb_hex_parser;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_strobe;
  logic [31:0] value;
  logic [3:0]  digits;
  logic        eol;
  logic        value_strobe;
  logic        error_strobe;

  int tests_run = 0;
  int tests_failed = 0;
  int vs_cnt = 0;
  int es_cnt = 0;
  int both_cnt = 0;
  logic last_vs, last_es;

  hex_parser #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_strobe    (in_strobe),
    .value        (value),
    .digits       (digits),
    .eol          (eol),
    .value_strobe (value_strobe),
    .error_strobe (error_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_strobe) vs_cnt++;
    if (error_strobe) es_cnt++;
    if (value_strobe && error_strobe) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_strobe = 1'b0;
    end
  endtask

  // Sends each character on its own strobe; the strobe state right after the
  // final byte is captured, then the bench waits for the counters to settle.
  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_data   = s[i];
      in_strobe = 1'b1;
      if (gap > 0 && i != s.len() - 1) idle(gap);
    end
    idle(1);
    last_vs = value_strobe;
    last_es = error_strobe;
    idle(2);
  endtask

  initial begin
    int vs0, es0;
    reset = 1'b0;
    in_data = 8'h00;
    in_strobe = 1'b0;
    #12;
    check("reset_value", value, 64'h0);
    check("reset_digits", digits, 64'h0);
    check("reset_eol", eol, 64'h0);
    check("reset_vs", value_strobe, 64'h0);
    check("reset_es", error_strobe, 64'h0);
    idle(1);
    reset = 1'b1;
    idle(2);

    send_str("1f\n", 0);
    check("t1_vs_pulse", last_vs, 64'h1);
    check("t1_vs_cnt", vs_cnt, 64'd1);
    check("t1_es_cnt", es_cnt, 64'd0);
    check("t1_value", value, 64'h1f);
    check("t1_digits", digits, 64'd2);
    check("t1_eol", eol, 64'h1);

    send_str("DEADbeef ", 2);
    check("t2_vs_cnt", vs_cnt, 64'd2);
    check("t2_es_cnt", es_cnt, 64'd0);
    check("t2_value", value, 64'hdeadbeef);
    check("t2_digits", digits, 64'd8);
    check("t2_eol", eol, 64'h0);

    send_str("123456789,", 0);
    check("t3_es_pulse", last_es, 64'h1);
    check("t3_vs_cnt", vs_cnt, 64'd2);
    check("t3_es_cnt", es_cnt, 64'd1);
    check("t3_value_kept", value, 64'hdeadbeef);
    check("t3_digits_kept", digits, 64'd8);

    send_str("12g4\r", 0);
    check("t4_es_cnt", es_cnt, 64'd2);
    check("t4_eol_kept", eol, 64'h0);
    send_str("7 ", 0);
    check("t4_vs_cnt", vs_cnt, 64'd3);
    check("t4_value", value, 64'h7);
    check("t4_digits", digits, 64'd1);
    check("t4_eol", eol, 64'h0);

    vs0 = vs_cnt; es0 = es_cnt;
    send_str("  \r\n,\t", 0);
    check("t5_no_vs", vs_cnt - vs0, 64'd0);
    check("t5_no_es", es_cnt - es0, 64'd0);
    check("t5_value_kept", value, 64'h7);

    send_str("ffffffff\r", 0);
    check("t6_value_max", value, 64'hffffffff);
    check("t6_digits_max", digits, 64'd8);
    check("t6_eol", eol, 64'h1);
    check("t6_vs_cnt", vs_cnt, 64'd4);

    send_str("007,", 1);
    check("t7_value_lz", value, 64'h7);
    check("t7_digits_lz", digits, 64'd3);
    check("t7_eol", eol, 64'h0);

    send_str("x\t", 0);
    check("t8_idle_invalid_es", es_cnt, 64'd3);
    check("t8_value_kept", value, 64'h7);

    send_str("ab", 0);
    #2;
    reset = 1'b0;
    #1;
    check("t9_rst_value", value, 64'h0);
    check("t9_rst_digits", digits, 64'd0);
    check("t9_rst_eol", eol, 64'h0);
    check("t9_rst_vs", value_strobe, 64'h0);
    idle(2);
    reset = 1'b1;
    idle(1);
    send_str("c\n", 0);
    check("t9_value", value, 64'hc);
    check("t9_digits", digits, 64'd1);
    check("t9_eol", eol, 64'h1);
    check("t9_vs_cnt", vs_cnt, 64'd6);
    check("never_both", both_cnt, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
